// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Two-requester memory arbiter. The instruction-fetch port and the
//             load/store data port share a single memory port. Data requests
//             win by default. After STARVE_MAX back-to-back data grants with a
//             fetch still waiting, the fetch is granted.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, reset             pipeline clock, asynchronous active-high reset
//    i_req/i_addr           fetch request and address
//    i_ok/i_data            fetch done pulse and the 32-bit instruction
//    d_req/d_write/d_addr   load/store request, store flag, address
//    d_size/d_wdata/d_strobe  log2 access size, store data, byte enables
//    d_ok/d_rdata           load/store done pulse and the 64-bit read word
//    m_*                    shared memory port (request side out, m_ok and
//                           m_rdata in)
//    busy                   high whenever the arbiter is not idle
// ============================================================================
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  // instruction port
  input  logic        i_req,
  input  logic [63:0] i_addr,
  output logic        i_ok,
  output logic [31:0] i_data,
  // data port
  input  logic        d_req,
  input  logic        d_write,
  input  logic [63:0] d_addr,
  input  logic [2:0]  d_size,
  input  logic [63:0] d_wdata,
  input  logic [7:0]  d_strobe,
  output logic        d_ok,
  output logic [63:0] d_rdata,
  // memory port
  output logic        m_req,
  output logic        m_write,
  output logic [63:0] m_addr,
  output logic [2:0]  m_size,
  output logic [63:0] m_wdata,
  output logic [7:0]  m_strobe,
  input  logic        m_ok,
  input  logic [63:0] m_rdata,
  // status
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;

  // Arbitration bookkeeping
  logic [2:0]  starve_cnt;
  logic [31:0] starve_ext;
  logic        starve_ok;
  logic        grant_i;
  logic        grant_d;
  logic        mem_done;

  // Request captured at the grant edge; the requester's live inputs are not
  // looked at again until the transaction has completed.
  logic        lat_write;
  logic [63:0] lat_addr;
  logic [2:0]  lat_size;
  logic [63:0] lat_wdata;
  logic [7:0]  lat_strobe;

  // Owner of the transaction that reached RESP (1 = data port)
  logic        owner_d;

  // Per-port read results; each holds until that port completes again
  logic [31:0] i_data_q;
  logic [63:0] d_rdata_q;

  assign starve_ext = {29'd0, starve_cnt};
  assign starve_ok  = (starve_ext < STARVE_MAX);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    mem_done   = 1'b0;
    m_req      = 1'b0;
    i_ok       = 1'b0;
    d_ok       = 1'b0;
    busy       = 1'b1;

    case (state)
      IDLE: begin
        busy = 1'b0;
        // Data has priority until its starvation budget is spent; once the
        // budget is gone a pending fetch wins, and data still goes through
        // if no fetch is waiting.
        if (d_req && starve_ok) begin
          grant_d    = 1'b1;
          state_next = GRANT_D;
        end else if (i_req) begin
          grant_i    = 1'b1;
          state_next = GRANT_I;
        end else if (d_req) begin
          grant_d    = 1'b1;
          state_next = GRANT_D;
        end
      end

      GRANT_I, GRANT_D: begin
        m_req = 1'b1;
        if (m_ok) begin
          mem_done   = 1'b1;
          state_next = RESP;
        end
      end

      RESP: begin
        i_ok       = ~owner_d;
        d_ok       = owner_d;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Starvation counter
  // Counts data grants issued while a fetch is waiting; any fetch grant, or
  // an idle cycle with no fetch pending, clears it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= 3'd0;
    end else if (state == IDLE) begin
      if (grant_i || !i_req) begin
        starve_cnt <= 3'd0;
      end else if (grant_d && (starve_cnt != 3'd7)) begin
        starve_cnt <= starve_cnt + 3'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Request capture at the grant edge
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_write  <= 1'b0;
      lat_addr   <= 64'd0;
      lat_size   <= 3'd0;
      lat_wdata  <= 64'd0;
      lat_strobe <= 8'd0;
    end else if (grant_d) begin
      lat_write  <= d_write;
      lat_addr   <= d_addr;
      lat_size   <= d_size;
      lat_wdata  <= d_wdata;
      lat_strobe <= d_strobe;
    end else if (grant_i) begin
      // Fetches are always 32-bit reads with no byte enables
      lat_write  <= 1'b0;
      lat_addr   <= i_addr;
      lat_size   <= 3'd2;
      lat_wdata  <= 64'd0;
      lat_strobe <= 8'h00;
    end
  end

  // --------------------------------------------------------------------------
  // Completion capture: memory data and owner are taken on the m_ok edge so
  // they are already stable during the single RESP cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_d   <= 1'b0;
      i_data_q  <= 32'd0;
      d_rdata_q <= 64'd0;
    end else if (mem_done) begin
      owner_d <= (state == GRANT_D);
      if (state == GRANT_D) begin
        d_rdata_q <= m_rdata;
      end else begin
        // Memory returns an aligned 64-bit word; address bit 2 picks the
        // instruction half.
        i_data_q <= lat_addr[2] ? m_rdata[63:32] : m_rdata[31:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output drive
  // --------------------------------------------------------------------------
  assign m_write  = lat_write;
  assign m_addr   = lat_addr;
  assign m_size   = lat_size;
  assign m_wdata  = lat_wdata;
  assign m_strobe = lat_strobe;
  assign i_data   = i_data_q;
  assign d_rdata  = d_rdata_q;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports, clock and reset first: clk in 1, pipeline clock; reset in 1, async active-high.
REQ-002 SHALL have instruction port: i_req in 1, fetch request; i_addr in 64, fetch address; i_ok out 1, fetch done pulse; i_data out 32, fetched instruction.
REQ-003 SHALL have data port: d_req in 1, load/store request; d_write in 1, 1 = store; d_addr in 64, effective address from decode; d_size in 3, log2 bytes; d_wdata in 64; d_strobe in 8, byte enables; d_ok out 1, done pulse; d_rdata out 64.
REQ-004 SHALL have memory port: m_req out 1; m_write out 1; m_addr out 64; m_size out 3; m_wdata out 64; m_strobe out 8; m_ok in 1, memory done; m_rdata in 64.
REQ-005 SHALL have busy out 1, high in any state other than IDLE.
REQ-006 SHALL have parameter STARVE_MAX, default 4, max consecutive data grants while i_req is pending.

Function
REQ-007 SHALL implement FSM states IDLE, GRANT_I, GRANT_D, RESP; reset state IDLE.
REQ-008 In IDLE, at clock edge: d_req and starve_cnt<STARVE_MAX -> GRANT_D; else i_req -> GRANT_I; else d_req -> GRANT_D; else stay IDLE.
REQ-009 On a grant edge, SHALL latch the granted requester's address/size/write/wdata/strobe; requester inputs are ignored until RESP.
REQ-010 Fetch grant SHALL drive m_write=0, m_size=3'd2, m_strobe=8'h00.
REQ-011 In GRANT_I/GRANT_D, m_req SHALL be 1 and memory outputs SHALL equal latched values; m_req SHALL be 0 in IDLE and RESP.
REQ-012 On m_ok=1 in GRANT_x, SHALL register m_rdata and the owner, then go to RESP at that edge.
REQ-013 In RESP, exactly the owner's ok (i_ok or d_ok) SHALL be 1 for one cycle; next state IDLE unconditionally.
REQ-014 i_data SHALL be latched m_rdata[63:32] when latched i_addr[2]=1, else [31:0]; d_rdata SHALL be the full latched word.
REQ-015 i_data/d_rdata SHALL hold their values until the next RESP.
REQ-016 Minimum latency: request in IDLE at edge N, m_ok in cycle N+1, ok in cycle N+2, next grant at edge N+3.
REQ-017 Requester SHALL drop req at the edge ending its ok cycle; a req still high in IDLE is a new request.
REQ-018 starve_cnt (3 bits, saturating) SHALL increment on each D grant while i_req=1 and reset to 0 on each I grant or when i_req=0 in IDLE.
REQ-019 m_ok in IDLE or RESP SHALL be ignored; no state, data or ok change.
REQ-020 Requests arriving while not IDLE SHALL wait, with no loss, until IDLE.

Reset
REQ-021 reset=1 SHALL force IDLE, starve_cnt=0, m_req=0, i_ok=0, d_ok=0, busy=0, and latched data/outputs to 0, asynchronously and regardless of state.
REQ-022 Reset mid-transaction SHALL abandon it with no ok pulse; the first grant after release follows REQ-008.

Verification
REQ-023 Fetch: i_req=1, i_addr=0x8000_0004, m_rdata=0x0000_0013_DEAD_BEEF after 3 wait cycles -> m_addr=0x8000_0004, m_size=2, one i_ok pulse, i_data=0x0000_0013.
REQ-024 Simultaneous i_req and d_req (load, d_addr=0x8000_1000, d_size=3) -> data granted first, d_ok, d_rdata=m_rdata; then fetch granted, i_ok.
REQ-025 Store: d_write=1, d_strobe=8'h0F, d_wdata=0x1122_3344_5566_7788 -> m_write=1, m_strobe=8'h0F, m_wdata matches; d_ok once; i_ok stays 0.
REQ-026 Starvation: i_req held high, d_req re-asserted every IDLE -> exactly 4 D grants, then 1 I grant, then D resumes.
REQ-027 reset pulsed two cycles into GRANT_D -> m_req=0 same cycle, no d_ok; after release with d_req=1 -> new GRANT_D with the current d_addr.
REQ-028 Spurious m_ok=1 in IDLE with no requests -> no ok pulse, busy=0, outputs unchanged.
